// File: rtl/display_pkg.sv
// Shared constants, BCD type and double-dabble helper for the vending display path.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned VALUE_W    = 14;
    localparam int unsigned BCD_W      = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned MAX_VALUE  = 9999;
    localparam int unsigned STEP_CNT_W = 4;

    localparam logic [NIBBLE_W-1:0] ERR_NIBBLE = 4'hE;

    typedef logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] bcd_t;

    // Add-3 correction on every nibble >= 5, applied ahead of each shift.
    function automatic bcd_t dd_adjust(input bcd_t b);
        bcd_t r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[i] = (b[i] >= NIBBLE_W'(5)) ? b[i] + NIBBLE_W'(3) : b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift step per cycle, VALUE_W steps per conversion.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VALUE_W-1:0] bin,
    output logic               busy,
    output logic               done_c,
    output bcd_t               bcd_c
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(VALUE_W - 1);

    logic [0:0]                  state;
    logic [0:0]                  state_nxt;
    logic [VALUE_W-1:0]          bin_sr;
    bcd_t                        bcd_sr;
    logic [STEP_CNT_W-1:0]       step;
    logic [BCD_W+VALUE_W-1:0]    shifted;

    // bcd_c is the value this step produces, so the final step's result is visible at its own edge.
    assign shifted = {dd_adjust(bcd_sr), bin_sr} << 1;
    assign bcd_c   = shifted[BCD_W+VALUE_W-1 -: BCD_W];
    assign busy    = (state == ST_CONV);
    assign done_c  = busy && (step == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CONV;
            ST_CONV: if (step == LAST_STEP) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            step   <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                bin_sr <= bin;
                bcd_sr <= '0;
                step   <= '0;
            end
        end else begin
            bin_sr <= shifted[VALUE_W-1:0];
            bcd_sr <= bcd_c;
            step   <= step + STEP_CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_scan_driver.sv
// Converts a loaded amount to BCD and time-multiplexes four digits onto the decoder nibble bus.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DP_POS      = 2,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    output logic                  busy,
    output logic [NIBBLE_W-1:0]   digit,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  dp_n
);

    localparam int unsigned DIV_W    = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
    localparam int unsigned LZ_FLOOR = (DP_POS >= NUM_DIGITS) ? 0 : DP_POS;
    localparam bit          DP_EN    = (DP_POS < NUM_DIGITS);
    localparam bit          LZ_EN    = (BLANK_LZ != 0);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] DP_IDX   = IDX_W'(DP_POS % NUM_DIGITS);

    logic             accept;
    logic             over;
    logic             conv_start;
    logic             conv_done;
    bcd_t             conv_bcd;
    bcd_t             disp;
    logic             err;
    logic [DIV_W-1:0] div;
    logic [IDX_W-1:0] idx;
    logic             upper_zero;
    logic             blank;

    assign accept     = load && !busy;
    assign over       = (value > VALUE_W'(MAX_VALUE));
    assign conv_start = accept && !over;

    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start),
        .bin    (value),
        .busy   (busy),
        .done_c (conv_done),
        .bcd_c  (conv_bcd)
    );

    // Display registers change only on a finished conversion or an out-of-range load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp <= '0;
            err  <= 1'b0;
        end else if (conv_done) begin
            disp <= conv_bcd;
            err  <= 1'b0;
        end else if (accept && over) begin
            err  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // A slot is blank when it sits above the decimal point and it and every higher digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx) && (disp[i] != '0)) upper_zero = 1'b0;
        end
        blank = LZ_EN && !err && (32'(idx) > LZ_FLOOR) && upper_zero;
    end

    always_comb begin
        digit = err ? ERR_NIBBLE : disp[idx];
        an_n  = blank ? '1 : ~(NUM_DIGITS'(1) << idx);
        dp_n  = !(DP_EN && (idx == DP_IDX) && !err);
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with REFRESH_DIV=4, DP_POS=2, BLANK_LZ=1.
module tb_display_scan_driver;

    typedef struct {
        logic [13:0] value;
        logic        is_err;
        logic [15:0] dig;   // expected nibble for slot i at [4i+:4]
        logic [15:0] an;    // expected an_n for slot i at [4i+:4]
        logic [3:0]  dp;    // expected dp_n for slot i at [i]
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [3:0]  digit;
    logic [3:0]  an_n;
    logic        dp_n;

    int cyc;
    int n_tests;
    int n_fail;

    entry_t tv [11];
    entry_t e_zero;
    entry_t e_700;

    display_scan_driver #(
        .REFRESH_DIV (4),
        .DP_POS      (2),
        .BLANK_LZ    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .load  (load),
        .busy  (busy),
        .digit (digit),
        .an_n  (an_n),
        .dp_n  (dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the scan slot follows as (cyc/4)%4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_disp(input entry_t e, input string name);
        int s;
        logic [8:0] exp;
        s   = (cyc / 4) % 4;
        exp = {e.dig[4*s +: 4], e.an[4*s +: 4], e.dp[s]};
        chk(name, 32'({digit, an_n, dp_n}), 32'(exp));
    endtask

    task automatic run_load(input entry_t e, input entry_t prev, input int inj_at,
                            input logic [13:0] inj_val);
        value = e.value;
        load  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        if (e.is_err) begin
            chk("err_busy", 32'(busy), 32'd0);
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                check_disp(e, "err_disp");
                @(negedge clk);
            end
        end else begin
            for (int i = 0; i < 14; i++) begin
                chk("busy_hi", 32'(busy), 32'd1);
                check_disp(prev, "hold_disp");
                if (i == inj_at) begin
                    value = inj_val;
                    load  = 1'b1;
                end else begin
                    load = 1'b0;
                end
                @(negedge clk);
            end
            load = 1'b0;
            chk("busy_lo", 32'(busy), 32'd0);
            for (int i = 0; i < 16; i++) begin
                check_disp(e, "new_disp");
                @(negedge clk);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        value   = '0;

        tv[0]  = '{14'd0,     1'b0, 16'h0000, 16'hFBDE, 4'hB};
        tv[1]  = '{14'd1234,  1'b0, 16'h1234, 16'h7BDE, 4'hB};
        tv[2]  = '{14'd5,     1'b0, 16'h0005, 16'hFBDE, 4'hB};
        tv[3]  = '{14'd10000, 1'b1, 16'hEEEE, 16'h7BDE, 4'hF};
        tv[4]  = '{14'd42,    1'b0, 16'h0042, 16'hFBDE, 4'hB};
        tv[5]  = '{14'd16383, 1'b1, 16'hEEEE, 16'h7BDE, 4'hF};
        tv[6]  = '{14'd9999,  1'b0, 16'h9999, 16'h7BDE, 4'hB};
        tv[7]  = '{14'd100,   1'b0, 16'h0100, 16'hFBDE, 4'hB};
        tv[8]  = '{14'd1000,  1'b0, 16'h1000, 16'h7BDE, 4'hB};
        tv[9]  = '{14'd9,     1'b0, 16'h0009, 16'hFBDE, 4'hB};
        tv[10] = '{14'd0,     1'b0, 16'h0000, 16'hFBDE, 4'hB};
        e_zero = tv[0];
        e_700  = '{14'd700,   1'b0, 16'h0700, 16'hFBDE, 4'hB};

        // Reset state and one full scan of "0.00".
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", 32'({digit, an_n, dp_n}), 32'({4'h0, 4'b1110, 1'b1}));
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("idle_busy", 32'(busy), 32'd0);
            check_disp(e_zero, "reset_disp");
            @(negedge clk);
        end

        run_load(tv[1], tv[0], -1, '0);
        // Load of 9999 three cycles into the conversion of 5 must be dropped.
        run_load(tv[2], tv[1], 2, 14'd9999);
        for (int t = 3; t < 11; t++) begin
            run_load(tv[t], tv[t-1], -1, '0);
        end

        // Reset in the middle of a conversion.
        value = 14'd9999;
        load  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out", 32'({digit, an_n, dp_n}), 32'({4'h0, 4'b1110, 1'b1}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("post_rst_busy", 32'(busy), 32'd0);
            check_disp(e_zero, "post_rst_disp");
            @(negedge clk);
        end
        run_load(e_700, e_zero, -1, '0);

        // Idle scanning: slot advance every 4 cycles with wrap, never two anodes on.
        for (int i = 0; i < 40; i++) begin
            check_disp(e_700, "idle_scan");
            chk("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
